dm_cache: RTL and testbench
===========================

DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 The module SHALL expose parameters, one per line:
  DATA_WIDTH, 16, data word width
  ADR_WIDTH, 16, word address width
  OFFSET_WIDTH, 2, word-in-block bits (4 words/block)
  INDEX_WIDTH, 6, line index bits (64 lines); TAG width = ADR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
REQ-002 The module SHALL have these ports, one per line:
  clk  input  1  single clock, all state on rising edge
  rst  input  1  synchronous, active-high reset
  cpu_adr  input  ADR_WIDTH  CPU word address
  cpu_wdata  input  DATA_WIDTH  CPU write data
  cpu_rdata  output  DATA_WIDTH  read data to CPU, registered
  cpu_rd  input  1  CPU read request, held until ready
  cpu_wr  input  1  CPU write request, held until ready
  ready  output  1  one-cycle completion pulse to CPU
  mem_adr  output  ADR_WIDTH  memory word address
  mem_wdata  output  DATA_WIDTH  memory write data
  mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ready=1
  mem_rd  output  1  memory read request
  mem_wr  output  1  memory write request
  mem_ready  input  1  memory completion, one cycle per word
REQ-003 The module SHALL use one clock (clk) and a synchronous active-high reset (rst).

Function
REQ-004 Organisation SHALL be direct-mapped, write-through, no-write-allocate; address split: offset [1:0], index [7:2], tag [15:8] at default parameters.
REQ-005 Storage per line SHALL be: valid bit, tag, 4 data words.
REQ-006 FSM states SHALL be IDLE, FILL, WMEM, RESP.
REQ-007 IDLE: requests sampled on each rising edge; cpu_wr has priority if cpu_rd and cpu_wr both high.
REQ-008 Read hit (valid and tag match) in IDLE: load cpu_rdata with the addressed word, go to RESP; ready high in the cycle after the sampling edge (1-cycle latency); no memory traffic.
REQ-009 Read miss: latch address, clear line valid, go to FILL; issue mem_rd for block words offset 0,1,2,3 in order with mem_adr = {tag,index,offset}.
REQ-010 FILL: mem_rd held with stable mem_adr until mem_ready sampled high; on that edge store mem_rdata in the line, advance offset; mem_rd may stay high across words.
REQ-011 After word 3 accepted: write tag, set valid, load cpu_rdata with requested word, drop mem_rd, go to RESP.
REQ-012 Write (hit or miss): latch address/data, go to WMEM; on hit update the cached word on the sampling edge; on miss leave line untouched.
REQ-013 WMEM: mem_wr=1, mem_adr=latched address, mem_wdata=latched data, held until mem_ready sampled high; then drop mem_wr, go to RESP.
REQ-014 RESP: ready=1 for exactly one cycle; next state IDLE; cpu_rd/cpu_wr ignored during RESP, so a held request is not re-executed; earliest new request sampled on the edge after RESP.
REQ-015 ready, mem_rd, mem_wr SHALL be registered, glitch-free; mem_rd and mem_wr never both high.
REQ-016 cpu_rdata SHALL hold its value until the next read completion; write completions leave it unchanged.
REQ-017 mem_ready outside FILL/WMEM SHALL be ignored.
REQ-018 Offset counter SHALL be OFFSET_WIDTH bits, wrapping 3->0 with no extra cycle.

Reset
REQ-019 On rst sampled high: state IDLE, all valid bits 0, ready=0, mem_rd=0, mem_wr=0, cpu_rdata=0, mem_adr=0, mem_wdata=0, offset counter 0; tag/data arrays need not be cleared.
REQ-020 Reset during FILL or WMEM SHALL abandon the transaction without asserting ready; the partially filled line remains invalid.

Verification
REQ-021 Write miss: write 0x0010=0x0751 with empty cache -> exactly one mem_wr at 0x0010/0x0751, no mem_rd, one ready pulse; line 4 stays invalid.
REQ-022 Read miss fill: memory holds 0x0751,0x1111,0x2222,0x3333 at 0x0010-0x0013, read 0x0011 -> mem_rd at 0x0010,0x0011,0x0012,0x0013 in order, cpu_rdata=0x1111 with ready.
REQ-023 Read hit: then read 0x0012 -> ready one cycle after sampling edge, cpu_rdata=0x2222, mem_rd/mem_wr stay 0.
REQ-024 Write hit: write 0x0013=0xBEEF then read 0x0013 -> one mem_wr, read is a hit returning 0xBEEF.
REQ-025 Conflict: read 0x0110 after the above -> 4-word refill at 0x0110-0x0113 (index 4, tag 0x01); subsequent read 0x0010 misses again.
REQ-026 Reset mid-fill: rst asserted after 2nd mem_ready of a fill -> no ready pulse, mem_rd=0 next cycle; repeat read of same address performs a full 4-word fill.

Source files
------------

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU and word-wide memory.
// Each line holds a valid bit, a tag and four data words.
module dm_cache #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADR_WIDTH    = 16,
    parameter int OFFSET_WIDTH = 2,
    parameter int INDEX_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADR_WIDTH-1:0]  cpu_adr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    output logic                  ready,
    output logic [ADR_WIDTH-1:0]  mem_adr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic                  mem_ready
);
    localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = LINES << OFFSET_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, WMEM, RESP} state_t;
    state_t state, next_state;

    logic [LINES-1:0]      valid;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [WORDS];

    logic [ADR_WIDTH-1:0]    req_adr;
    logic [OFFSET_WIDTH-1:0] off, off_inc;
    logic                    ready_d, mem_rd_d, mem_wr_d;

    logic [TAG_WIDTH-1:0]    cpu_tag, req_tag;
    logic [INDEX_WIDTH-1:0]  cpu_idx, req_idx;
    logic [OFFSET_WIDTH-1:0] cpu_off, req_off;
    logic                    hit;

    assign cpu_tag = cpu_adr[ADR_WIDTH-1 -: TAG_WIDTH];
    assign cpu_idx = cpu_adr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_off = cpu_adr[OFFSET_WIDTH-1:0];
    assign req_tag = req_adr[ADR_WIDTH-1 -: TAG_WIDTH];
    assign req_idx = req_adr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off = req_adr[OFFSET_WIDTH-1:0];
    assign hit     = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign off_inc = off + OFFSET_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu_wr)      next_state = WMEM;
                else if (cpu_rd) next_state = hit ? RESP : FILL;
            end
            FILL:    if (mem_ready && off == '1) next_state = RESP;
            WMEM:    if (mem_ready) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are a registered decode of the upcoming state.
    always_comb begin
        ready_d  = (next_state == RESP);
        mem_rd_d = (next_state == FILL);
        mem_wr_d = (next_state == WMEM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready  <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            ready  <= ready_d;
            mem_rd <= mem_rd_d;
            mem_wr <= mem_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            off       <= '0;
            req_adr   <= '0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        req_adr   <= cpu_adr;
                        mem_adr   <= cpu_adr;
                        mem_wdata <= cpu_wdata;
                    end else if (cpu_rd) begin
                        if (hit) begin
                            cpu_rdata <= data_mem[{cpu_idx, cpu_off}];
                        end else begin
                            req_adr        <= cpu_adr;
                            valid[cpu_idx] <= 1'b0;
                            off            <= '0;
                            mem_adr        <= {cpu_tag, cpu_idx, OFFSET_WIDTH'(0)};
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        off     <= off_inc;
                        mem_adr <= {req_tag, req_idx, off_inc};
                        if (off == '1) begin
                            valid[req_idx] <= 1'b1;
                            // The last word is only on mem_rdata this cycle; earlier ones are already stored.
                            cpu_rdata <= (req_off == '1) ? mem_rdata : data_mem[{req_idx, req_off}];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && cpu_wr && hit)
                data_mem[{cpu_idx, cpu_off}] <= cpu_wdata;
            if (state == FILL && mem_ready) begin
                data_mem[{req_idx, off}] <= mem_rdata;
                if (off == '1) tag_mem[req_idx] <= req_tag;
            end
        end
    end
endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: flat-memory / line-map reference model, randomised
// memory latency and spurious mem_ready, directed scenarios followed by random traffic.
module tb_dm_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr, ready;
    logic [15:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_ready;

    always #5 clk = ~clk;

    dm_cache #(
        .DATA_WIDTH(16),
        .ADR_WIDTH(16),
        .OFFSET_WIDTH(2),
        .INDEX_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .ready(ready),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
    );

    typedef struct {
        bit          wr;
        logic [15:0] adr;
        logic [15:0] data;
    } acc_t;

    logic [15:0] mem_arr [65536];  // memory as seen by the DUT
    logic [15:0] ref_mem [65536];  // what memory should hold
    bit          mvalid  [64];
    logic [7:0]  mtag    [64];
    acc_t        acc_log [$];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   started = 0;
    bit   acc_edge = 0;
    int   wait_cnt = 0;
    logic        prev_ready, prev_rd;
    logic [15:0] prev_rdata, prev_adr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory acceptance log; a transfer completes on the edge where mem_ready is seen high.
    always @(posedge clk) begin
        acc_t e;
        acc_edge = 0;
        if (!rst && mem_ready && (mem_rd || mem_wr)) begin
            e.wr   = mem_wr;
            e.adr  = mem_adr;
            e.data = mem_wr ? mem_wdata : mem_rdata;
            acc_log.push_back(e);
            if (mem_wr) mem_arr[mem_adr] = mem_wdata;
            acc_edge = 1;
        end
    end

    // Memory responder with random latency; idle cycles get stray mem_ready pulses.
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            wait_cnt  = 0;
        end else if (mem_rd || mem_wr) begin
            if (wait_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_arr[mem_adr];
                wait_cnt  = $urandom_range(0, 2);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
                wait_cnt--;
            end
        end else begin
            mem_ready = ($urandom_range(0, 5) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    // Per-cycle protocol checks.
    always @(negedge clk) begin
        if (started && !rst) begin
            n_cmp++;
            if (mem_rd && mem_wr) begin
                n_bad++;
                $display("FAIL rd_wr_exclusive: got mem_rd=1 mem_wr=1, expected at most one");
            end else if (ready && prev_ready) begin
                n_bad++;
                $display("FAIL ready_width: got ready high two cycles, expected one");
            end else if (!ready && cpu_rdata !== prev_rdata) begin
                n_bad++;
                $display("FAIL rdata_hold: got 0x%0h, expected 0x%0h", cpu_rdata, prev_rdata);
            end else if (mem_rd && prev_rd && !acc_edge && mem_adr !== prev_adr) begin
                n_bad++;
                $display("FAIL adr_stable: got 0x%0h, expected 0x%0h", mem_adr, prev_adr);
            end
        end
        prev_ready = ready;
        prev_rd    = mem_rd;
        prev_rdata = cpu_rdata;
        prev_adr   = mem_adr;
    end

    task automatic do_txn(input bit wr, input logic [15:0] a, input logic [15:0] d, input bit hold,
                          output logic [15:0] rd, output int nacc, output int lat);
        logic [5:0]  idx;
        logic [7:0]  tg;
        bit          hit, got;
        logic [15:0] rd_before;
        idx = a[7:2];
        tg  = a[15:8];
        hit = mvalid[idx] && (mtag[idx] == tg);
        @(negedge clk);
        rd_before = cpu_rdata;
        acc_log.delete();
        cpu_adr   = a;
        cpu_wdata = d;
        cpu_wr    = wr;
        cpu_rd    = !wr;
        got = 0;
        lat = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ready) got = 1;
        end
        chk("ready_timeout", 32'(got), 32'd1);
        rd   = cpu_rdata;
        nacc = acc_log.size();
        if (wr) begin
            chk("wr_count", nacc, 1);
            if (nacc >= 1) begin
                chk("wr_kind", 32'(acc_log[0].wr), 32'd1);
                chk("wr_adr", acc_log[0].adr, a);
                chk("wr_data", acc_log[0].data, d);
            end
            chk("wr_keeps_rdata", cpu_rdata, rd_before);
            ref_mem[a] = d;
        end else begin
            chk("rd_data", cpu_rdata, ref_mem[a]);
            if (hit) begin
                chk("hit_no_traffic", nacc, 0);
                chk("hit_latency", lat, 1);
            end else begin
                chk("fill_count", nacc, 4);
                for (int k = 0; k < 4 && k < nacc; k++) begin
                    chk("fill_kind", 32'(acc_log[k].wr), 32'd0);
                    chk("fill_adr", acc_log[k].adr, {a[15:2], 2'(k)});
                end
                mvalid[idx] = 1;
                mtag[idx]   = tg;
            end
        end
        if (hold) begin
            @(negedge clk);
            chk("held_req_ignored", {ready, mem_rd, mem_wr}, 32'd0);
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    initial begin
        logic [15:0] r, v;
        int          n, l;
        bit          got;
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = 16'((i * 40503) ^ 'h3C5A);
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16'h0000 : 16'(i * 'h1111);
            mem_arr[16 + i]  = v;
            ref_mem[16 + i]  = v;
            mem_arr[272 + i] = 16'hA110 + 16'(i);
            ref_mem[272 + i] = 16'hA110 + 16'(i);
        end
        for (int i = 0; i < 64; i++) mvalid[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        started = 1;

        do_txn(1, 16'h0010, 16'h0751, 0, r, n, l);
        chk("wmiss_mem", mem_arr[16], 16'h0751);
        do_txn(0, 16'h0011, 16'h0000, 1, r, n, l);
        chk("fill_lit_data", r, 16'h1111);
        chk("fill_lit_count", n, 4);
        do_txn(0, 16'h0012, 16'h0000, 0, r, n, l);
        chk("hit_lit_data", r, 16'h2222);
        chk("hit_lit_count", n, 0);
        chk("hit_lit_latency", l, 1);
        do_txn(1, 16'h0013, 16'hBEEF, 1, r, n, l);
        do_txn(0, 16'h0013, 16'h0000, 0, r, n, l);
        chk("whit_lit_data", r, 16'hBEEF);
        chk("whit_lit_count", n, 0);
        do_txn(0, 16'h0110, 16'h0000, 0, r, n, l);
        chk("conflict_lit_data", r, 16'hA110);
        chk("conflict_lit_count", n, 4);
        do_txn(0, 16'h0010, 16'h0000, 0, r, n, l);
        chk("refill_lit_data", r, 16'h0751);
        chk("refill_lit_count", n, 4);

        // Reset in the middle of a fill.
        @(negedge clk);
        acc_log.delete();
        cpu_adr = 16'h0230;
        cpu_rd  = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (acc_log.size() >= 2) got = 1;
        end
        chk("midfill_two_words", 32'(got), 32'd1);
        chk("midfill_no_ready", ready, 0);
        rst = 1'b1;
        cpu_rd = 1'b0;
        @(negedge clk);
        chk("midfill_ready_after_rst", ready, 0);
        chk("midfill_mem_rd_after_rst", mem_rd, 0);
        chk("midfill_rdata_after_rst", cpu_rdata, 0);
        chk("midfill_words_kept", acc_log.size(), 2);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mvalid[i] = 0;
        do_txn(0, 16'h0230, 16'h0000, 0, r, n, l);
        chk("refill_after_rst_count", n, 4);
        do_txn(0, 16'h0012, 16'h0000, 0, r, n, l);
        chk("miss_after_rst_count", n, 4);
        chk("miss_after_rst_data", r, 16'h2222);

        for (int t = 0; t < 300; t++) begin
            logic [15:0] a;
            a = {8'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_txn($urandom_range(0, 2) == 0, a, 16'($urandom), 1'($urandom_range(0, 1)), r, n, l);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
